// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bundle: raw buttons, counter datapath link and display/status outputs.
// The controller connects through the slave modport; the driving environment uses master.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lr;
    logic [9:0] cont_seg;
    logic [3:0] cont_dec;
    logic       cnt_en;
    logic       cnt_clr;
    logic [9:0] disp_seg;
    logic [3:0] disp_dec;
    logic [1:0] state;
    logic       lap_valid;
    logic [3:0] lap_num;

    modport master (
        output btn_ss, btn_lr, cont_seg, cont_dec,
        input  cnt_en, cnt_clr, disp_seg, disp_dec, state, lap_valid, lap_num
    );

    modport slave (
        input  btn_ss, btn_lr, cont_seg, cont_dec,
        output cnt_en, cnt_clr, disp_seg, disp_dec, state, lap_valid, lap_num
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronises and debounces two buttons, runs the IDLE/RUN/LAP/STOP FSM,
// captures lap times and drives the registered display.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE = 4
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StLap  = 2'b10,
        StStop = 2'b11
    } state_e;

    localparam logic [7:0] DbLast = 8'(DEBOUNCE - 1);

    // Bit 0 is start/stop, bit 1 is lap/reset.
    logic [1:0] raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] deb_q, deb_prev_q;
    logic [7:0] db_cnt_q [2];
    logic [1:0] press;
    logic       ss_ev, lr_ev;

    state_e     state_q, state_d;
    logic       capture, clear, cnt_en;
    logic       cnt_clr_q;
    logic       lap_valid_q, lap_valid_d;
    logic [3:0] lap_num_q, lap_num_d;
    logic [9:0] lap_seg_q, lap_seg_d;
    logic [3:0] lap_dec_q, lap_dec_d;
    logic [9:0] disp_seg_q, disp_seg_d;
    logic [3:0] disp_dec_q, disp_dec_d;

    assign raw   = {bus.btn_lr, bus.btn_ss};
    assign press = deb_q & ~deb_prev_q;
    assign ss_ev = press[0];
    // Start/stop wins a same-cycle collision; the lap/reset press is dropped.
    assign lr_ev = press[1] & ~press[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    deb_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (ss_ev) state_d = StRun;
            StRun: begin
                if (ss_ev) begin
                    state_d = StStop;
                end else if (lr_ev) begin
                    state_d = StLap;
                end
            end
            StLap: if (ss_ev) state_d = StStop;
            StStop: begin
                if (ss_ev) begin
                    state_d = StRun;
                end else if (lr_ev) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_en      = (state_q == StRun) || (state_q == StLap);
        capture     = lr_ev && cnt_en;
        clear       = lr_ev && !cnt_en;
        lap_seg_d   = capture ? bus.cont_seg : lap_seg_q;
        lap_dec_d   = capture ? bus.cont_dec : lap_dec_q;
        lap_num_d   = lap_num_q;
        if (clear) begin
            lap_num_d = '0;
        end else if (capture && (lap_num_q != 4'd15)) begin
            lap_num_d = lap_num_q + 4'd1;
        end
        lap_valid_d = (state_d == StLap);
        // Display follows the state being entered so it flips in step with state.
        disp_seg_d  = lap_valid_d ? lap_seg_d : bus.cont_seg;
        disp_dec_d  = lap_valid_d ? lap_dec_d : bus.cont_dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_clr_q   <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_num_q   <= '0;
            lap_seg_q   <= '0;
            lap_dec_q   <= '0;
            disp_seg_q  <= '0;
            disp_dec_q  <= '0;
        end else begin
            cnt_clr_q   <= clear;
            lap_valid_q <= lap_valid_d;
            lap_num_q   <= lap_num_d;
            lap_seg_q   <= lap_seg_d;
            lap_dec_q   <= lap_dec_d;
            disp_seg_q  <= disp_seg_d;
            disp_dec_q  <= disp_dec_d;
        end
    end

    assign bus.cnt_en    = cnt_en;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.disp_seg  = disp_seg_q;
    assign bus.disp_dec  = disp_dec_q;
    assign bus.state     = state_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.lap_num   = lap_num_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random button traffic, every cycle
// compared against a sliding-window behavioural model of the button path and FSM.
module tb_stopwatch_ctrl;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DEBOUNCE(D)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    bit hold_cont = 1'b0;

    // Model: 0=IDLE 1=RUN 2=LAP 3=STOP
    int nxt_ss [4] = '{1, 3, 3, 1};
    int nxt_lr [4] = '{0, 2, 2, 0};
    int m_state, m_lapnum, m_lap_seg, m_lap_dec, m_disp_seg, m_disp_dec;
    bit m_clr, m_lapv;
    bit [15:0] hist [2];
    bit m_deb [2];
    bit m_pend [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ss, lr, all_diff, r;
        int old;
        if (reset) begin
            m_state = 0; m_lapnum = 0; m_lap_seg = 0; m_lap_dec = 0;
            m_disp_seg = 0; m_disp_dec = 0; m_clr = 0; m_lapv = 0;
            for (int b = 0; b < 2; b++) begin
                hist[b] = '0; m_deb[b] = 0; m_pend[b] = 0;
            end
        end else begin
            ss    = m_pend[0];
            lr    = m_pend[1] && !ss;
            old   = m_state;
            m_clr = 0;
            if (ss) begin
                m_state = nxt_ss[old];
            end else if (lr) begin
                m_state = nxt_lr[old];
                if (old == 0 || old == 3) begin
                    m_clr = 1; m_lapnum = 0;
                end else begin
                    m_lap_seg = bus.cont_seg; m_lap_dec = bus.cont_dec;
                    if (m_lapnum < 15) m_lapnum++;
                end
            end
            m_lapv     = (m_state == 2);
            m_disp_seg = m_lapv ? m_lap_seg : int'(bus.cont_seg);
            m_disp_dec = m_lapv ? m_lap_dec : int'(bus.cont_dec);
            // Debounced level flips once the raw level seen 2..D+1 edges ago all differs from it.
            for (int b = 0; b < 2; b++) begin
                r = (b == 0) ? bus.btn_ss : bus.btn_lr;
                hist[b] = {hist[b][14:0], r};
                m_pend[b] = 0;
                all_diff = 1;
                for (int j = 2; j <= D + 1; j++) begin
                    if (hist[b][j] == m_deb[b]) all_diff = 0;
                end
                if (all_diff) begin
                    m_deb[b]  = !m_deb[b];
                    m_pend[b] = m_deb[b];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("state", 32'(bus.state), 32'(m_state));
        chk("cnt_en", 32'(bus.cnt_en), 32'(m_state == 1 || m_state == 2));
        chk("cnt_clr", 32'(bus.cnt_clr), 32'(m_clr));
        chk("disp_seg", 32'(bus.disp_seg), 32'(m_disp_seg));
        chk("disp_dec", 32'(bus.disp_dec), 32'(m_disp_dec));
        chk("lap_valid", 32'(bus.lap_valid), 32'(m_lapv));
        chk("lap_num", 32'(bus.lap_num), 32'(m_lapnum));
        if (!hold_cont) begin
            bus.cont_seg = 10'($urandom_range(0, 999));
            bus.cont_dec = 4'($urandom_range(0, 9));
        end
    endtask

    task automatic press(input bit ss, input bit lr, input int hold);
        bus.btn_ss = ss;
        bus.btn_lr = lr;
        repeat (hold) tick();
        bus.btn_ss = 0;
        bus.btn_lr = 0;
        repeat (D + 4) tick();
    endtask

    initial begin
        reset = 1; bus.btn_ss = 0; bus.btn_lr = 0; bus.cont_seg = 0; bus.cont_dec = 0;
        tick(); tick();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_disp", 32'(bus.disp_seg), 0);
        reset = 0;
        repeat (3) tick();

        // Held start/stop: RUN exactly at edge D+3, stable while held.
        bus.btn_ss = 1;
        repeat (D + 2) tick();
        chk("ss_not_yet", 32'(bus.state), 0);
        tick();
        chk("ss_run", 32'(bus.state), 1);
        chk("ss_cnt_en", 32'(bus.cnt_en), 1);
        repeat (5) tick();
        chk("ss_held", 32'(bus.state), 1);
        bus.btn_ss = 0;
        repeat (D + 4) tick();

        // Lap capture of 12.3, held while the counter advances.
        hold_cont = 1; bus.cont_seg = 12; bus.cont_dec = 3; bus.btn_lr = 1;
        repeat (D + 3) tick();
        hold_cont = 0;
        chk("lap_state", 32'(bus.state), 2);
        chk("lap_valid1", 32'(bus.lap_valid), 1);
        chk("lap_num1", 32'(bus.lap_num), 1);
        chk("lap_seg", 32'(bus.disp_seg), 12);
        chk("lap_dec", 32'(bus.disp_dec), 3);
        repeat (4) tick();
        chk("lap_seg_hold", 32'(bus.disp_seg), 12);
        bus.btn_lr = 0;
        repeat (D + 4) tick();
        press(0, 1, D + 3);
        chk("lap_num2", 32'(bus.lap_num), 2);

        // STOP then lap/reset: back to IDLE with a single clear pulse.
        press(1, 0, D + 3);
        chk("stop_state", 32'(bus.state), 3);
        bus.btn_lr = 1;
        repeat (D + 3) tick();
        chk("clr_idle", 32'(bus.state), 0);
        chk("clr_pulse", 32'(bus.cnt_clr), 1);
        chk("clr_lapnum", 32'(bus.lap_num), 0);
        chk("clr_cnt_en", 32'(bus.cnt_en), 0);
        tick();
        chk("clr_one_cycle", 32'(bus.cnt_clr), 0);
        bus.btn_lr = 0;
        repeat (D + 4) tick();

        // Short glitch in RUN is ignored.
        press(1, 0, D + 3);
        bus.btn_ss = 1;
        repeat (3) tick();
        bus.btn_ss = 0;
        repeat (D + 4) tick();
        chk("glitch", 32'(bus.state), 1);

        // Simultaneous presses in RUN: start/stop wins, lap count untouched.
        press(0, 1, D + 3);
        press(1, 0, D + 3);
        press(1, 0, D + 3);
        press(1, 1, D + 3);
        chk("both_stop", 32'(bus.state), 3);
        chk("both_lapnum", 32'(bus.lap_num), 1);

        // Lap count saturation.
        press(1, 0, D + 3);
        for (int i = 0; i < 16; i++) press(0, 1, D + 3);
        chk("lap_sat", 32'(bus.lap_num), 15);
        chk("lap_sat_state", 32'(bus.state), 2);

        // Reset in LAP with start/stop held through release.
        reset = 1; bus.btn_ss = 1;
        tick();
        chk("rst_lap_state", 32'(bus.state), 0);
        chk("rst_lap_valid", 32'(bus.lap_valid), 0);
        chk("rst_lap_num", 32'(bus.lap_num), 0);
        chk("rst_lap_disp", 32'(bus.disp_seg), 0);
        tick();
        reset = 0;
        repeat (D + 2) tick();
        chk("rst_hold_early", 32'(bus.state), 0);
        tick();
        chk("rst_hold_event", 32'(bus.state), 1);
        bus.btn_ss = 0;
        repeat (D + 4) tick();

        // Random button traffic with occasional resets.
        for (int s = 0; s < 250; s++) begin
            bus.btn_ss = 1'($urandom_range(0, 1));
            bus.btn_lr = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 39) == 0);
            repeat ($urandom_range(1, D + 4)) tick();
        end
        reset = 0; bus.btn_ss = 0; bus.btn_lr = 0;
        repeat (D + 4) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable cycles required before a button level change is accepted; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_ss  input  1  raw start/stop button, asynchronous, active-high.
REQ-005 btn_lr  input  1  raw lap/reset button, asynchronous, active-high.
REQ-006 cont_seg  input  10  seconds value from counter datapath.
REQ-007 cont_dec  input  4  tenths value from counter datapath.
REQ-008 cnt_en  output  1  counter enable.
REQ-009 cnt_clr  output  1  counter clear pulse.
REQ-010 disp_seg  output  10  displayed seconds.
REQ-011 disp_dec  output  4  displayed tenths.
REQ-012 state  output  2  FSM state: IDLE=00, RUN=01, LAP=10, STOP=11.
REQ-013 lap_valid  output  1  high while the display shows a frozen lap.
REQ-014 lap_num  output  4  count of laps taken since the last clear.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE consecutive cycles.
REQ-016 A press event SHALL be a one-cycle internal pulse on a debounced 0->1 transition; releases SHALL generate no event.
REQ-017 Latency: state SHALL update on clock edge DEBOUNCE+3, counted from the first edge that samples the raw button high (edge 1), provided the button is held.
REQ-018 Glitches shorter than DEBOUNCE synchronized cycles SHALL produce no event.
REQ-019 IDLE: ss event -> RUN; lr event -> stay IDLE with a cnt_clr pulse.
REQ-020 RUN: ss event -> STOP; lr event -> LAP, capturing cont_seg/cont_dec into lap registers on the same edge.
REQ-021 RUN -> LAP SHALL increment lap_num; lap_num saturates at 15.
REQ-022 LAP: lr event -> LAP again with a fresh capture and lap_num increment; ss event -> STOP.
REQ-023 STOP: ss event -> RUN; lr event -> IDLE with a cnt_clr pulse and lap_num cleared to 0.
REQ-024 LAP SHALL be left only by an ss event or by reset.
REQ-025 If ss and lr events occur on the same cycle, ss SHALL take priority and the lr event SHALL be discarded.
REQ-026 cnt_en SHALL be 1 exactly when state is RUN or LAP.
REQ-027 cnt_clr SHALL be high for exactly one cycle, on the cycle after the edge that takes the lr action (REQ-019, REQ-023), and low otherwise.
REQ-028 disp_seg/disp_dec SHALL be registered, with 1-cycle latency:
- In LAP: the lap registers.
- In all other states: cont_seg/cont_dec sampled on the previous edge.
REQ-029 lap_valid SHALL equal (state == LAP), registered coincident with state.

Reset
REQ-030 While reset is high at a clock edge, the following SHALL be forced:
- state = IDLE; cnt_en = 0; cnt_clr = 0; lap_valid = 0.
- lap_num = 0; disp_seg = 0; disp_dec = 0; lap registers = 0.
- Synchronizers, debounced levels and debounce counters = 0.
REQ-031 Reset SHALL override any pending or simultaneous button event; a button held through reset release SHALL produce an event only after a full debounce from reset release.
REQ-032 Reset asserted in any state SHALL return the block to IDLE on the next edge.

Verification (DEBOUNCE=4)
REQ-033 Hold btn_ss high from edge 1 in IDLE -> state=RUN and cnt_en=1 at edge 7; no further change while held.
REQ-034 In RUN, press btn_lr with cont_seg=12, cont_dec=3 at the capture edge -> state=LAP, lap_valid=1, lap_num=1, disp shows 12.3 and holds while the inputs advance; a second lr press -> lap_num=2, new capture.
REQ-035 In STOP, press btn_lr -> state=IDLE, cnt_clr high for exactly one cycle, lap_num=0, cnt_en=0.
REQ-036 In RUN, press btn_ss and btn_lr with identical timing -> state=STOP and lap_num unchanged.
REQ-037 In RUN, pulse btn_ss high for 3 cycles -> no state change; assert reset while in LAP -> next edge state=IDLE and all outputs 0.
REQ-038 In LAP, take 16 laps -> lap_num saturates at 15.
